// File: rtl/display_update_scheduler_pkg.sv
// Shared types and constants for the OLED update scheduler and the 7-seg decoder.
package display_update_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_e;

    // Nibble the 7-seg decoder renders with every segment off.
    localparam logic [3:0] BLANK_CODE = 4'hF;

endpackage

// File: rtl/display_update_scheduler_leading_zero_blanker.sv
// Combinational leading-zero blanking; nibble 0 is the leftmost digit on screen.
module leading_zero_blanker #(
    parameter int         DIGITS_NUM    = 6,
    parameter logic [3:0] BLANK_CODE    = 4'hF,
    parameter int         BLANK_LEADING = 1
) (
    input  logic [4*DIGITS_NUM-1:0] raw,
    output logic [4*DIGITS_NUM-1:0] blanked
);

    logic seen_s;

    // Walk left to right; zeros before the first nonzero digit go blank, last digit always shown.
    always_comb begin
        blanked = raw;
        seen_s  = 1'b0;
        for (int i = 0; i < DIGITS_NUM; i++) begin
            if (raw[4*i +: 4] != 4'h0) begin
                seen_s = 1'b1;
            end else begin
                seen_s = seen_s;
            end
            if ((BLANK_LEADING != 0) && !seen_s && (i != DIGITS_NUM - 1)) begin
                blanked[4*i +: 4] = BLANK_CODE;
            end else begin
                blanked[4*i +: 4] = raw[4*i +: 4];
            end
        end
    end

endmodule

// File: rtl/display_update_scheduler.sv
// Decides when the OLED is redrawn: newest-wins buffer, redraw holdoff, skip-unchanged,
// leading-zero blanking and a watchdog on the data_streamer handshake.
module display_update_scheduler
    import display_update_scheduler_pkg::*;
#(
    parameter int         DIGITS_NUM     = 6,
    parameter int         MIN_INTERVAL   = 1000000,
    parameter int         TIMEOUT_CYCLES = 2000000,
    parameter int         BLANK_LEADING  = 1,
    parameter logic [3:0] BLANK_CODE     = display_update_scheduler_pkg::BLANK_CODE,
    parameter int         SKIP_UNCHANGED = 1
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic [4*DIGITS_NUM-1:0] meas_digits,
    input  logic                    meas_valid,
    input  logic                    force_refresh,
    output logic [4*DIGITS_NUM-1:0] digits,
    output logic                    write_stb,
    input  logic                    streamer_ready,
    output logic                    busy,
    output logic                    pending,
    output logic [7:0]              drop_cnt,
    output logic                    timeout_err
);

    localparam int DW = 4 * DIGITS_NUM;
    localparam int HW = $clog2(MIN_INTERVAL + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(MIN_INTERVAL - 1);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);

    state_e          state_r, state_nx_s;
    logic [DW-1:0]   pend_data_r, last_shown_r, digits_r, src_s, blanked_s;
    logic            pend_vld_r, force_r, write_stb_r, timeout_r;
    logic [HW-1:0]   holdoff_r;
    logic [WW-1:0]   wd_r;
    logic [7:0]      drop_r;
    logic            issue_s, skip_s, timeout_s;

    leading_zero_blanker #(
        .DIGITS_NUM    (DIGITS_NUM),
        .BLANK_CODE    (BLANK_CODE),
        .BLANK_LEADING (BLANK_LEADING)
    ) u_blanker (
        .raw     (src_s),
        .blanked (blanked_s)
    );

    // Next-state and per-cycle control decisions.
    always_comb begin
        state_nx_s = state_r;
        issue_s    = 1'b0;
        skip_s     = 1'b0;
        timeout_s  = 1'b0;
        src_s      = pend_vld_r ? pend_data_r : last_shown_r;
        case (state_r)
            S_IDLE: begin
                if ((holdoff_r == '0) && (pend_vld_r || force_r)) begin
                    if ((SKIP_UNCHANGED != 0) && (pend_data_r == last_shown_r) && !force_r) begin
                        skip_s = 1'b1;
                    end else begin
                        state_nx_s = S_ISSUE;
                    end
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (streamer_ready) begin
                    issue_s    = 1'b1;
                    state_nx_s = S_WAIT_BUSY;
                end else if (wd_r == WD_LAST) begin
                    timeout_s  = 1'b1;
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_ISSUE;
                end
            end
            S_WAIT_BUSY: begin
                if (!streamer_ready) begin
                    state_nx_s = S_WAIT_DONE;
                end else if (wd_r == WD_LAST) begin
                    timeout_s  = 1'b1;
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_WAIT_BUSY;
                end
            end
            S_WAIT_DONE: begin
                if (streamer_ready) begin
                    state_nx_s = S_IDLE;
                end else if (wd_r == WD_LAST) begin
                    timeout_s  = 1'b1;
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_WAIT_DONE;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // State register plus buffer, holdoff, watchdog and output registers.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_r      <= S_IDLE;
            pend_data_r  <= '0;
            pend_vld_r   <= 1'b0;
            last_shown_r <= '0;
            force_r      <= 1'b0;
            holdoff_r    <= '0;
            wd_r         <= '0;
            digits_r     <= '0;
            write_stb_r  <= 1'b0;
            drop_r       <= 8'd0;
            timeout_r    <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            write_stb_r <= issue_s;
            if (issue_s) begin
                digits_r     <= blanked_s;
                last_shown_r <= src_s;
            end
            // A capture on the issue cycle refills the buffer rather than being lost.
            if (meas_valid) begin
                pend_data_r <= meas_digits;
                pend_vld_r  <= 1'b1;
            end else if (issue_s || skip_s) begin
                pend_vld_r  <= 1'b0;
            end
            if (meas_valid && pend_vld_r && !issue_s && (drop_r != 8'hFF)) begin
                drop_r <= drop_r + 8'd1;
            end
            if (force_refresh) begin
                force_r <= 1'b1;
            end else if (issue_s) begin
                force_r <= 1'b0;
            end
            if (issue_s) begin
                holdoff_r <= HOLD_LOAD;
            end else if (holdoff_r != '0) begin
                holdoff_r <= holdoff_r - HW'(1);
            end
            if ((state_nx_s != state_r) || (state_r == S_IDLE)) begin
                wd_r <= '0;
            end else begin
                wd_r <= wd_r + WW'(1);
            end
            if (timeout_s) begin
                timeout_r <= 1'b1;
            end
        end
    end

    assign digits      = digits_r;
    assign write_stb   = write_stb_r;
    assign busy        = (state_r != S_IDLE);
    assign pending     = pend_vld_r;
    assign drop_cnt    = drop_r;
    assign timeout_err = timeout_r;

endmodule

// File: tb/tb_display_update_scheduler.sv
// Bench for display_update_scheduler: directed scenarios plus randomized rounds against a
// transaction-level model (latest value wins, unchanged skipped, drops = captures while full).
module tb_display_update_scheduler;

    localparam int DN = 6;
    localparam int DW = 4 * DN;

    logic          clk_in = 1'b0;
    logic          reset_in;
    logic [DW-1:0] meas_digits;
    logic          meas_valid;
    logic          force_refresh;
    logic          streamer_ready;
    logic [DW-1:0] digits, nb_digits;
    logic          write_stb, busy, pending, timeout_err;
    logic          nb_write_stb, nb_busy, nb_pending, nb_timeout_err;
    logic [7:0]    drop_cnt, nb_drop_cnt;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            stb_cnt = 0;
    logic [DW-1:0] stb_dig, stb_dig_nb;
    bit            stuck = 1'b0;
    logic [DW-1:0] exp_last = '0;
    int            exp_drop = 0;

    display_update_scheduler #(
        .DIGITS_NUM(DN), .MIN_INTERVAL(20), .TIMEOUT_CYCLES(50),
        .BLANK_LEADING(1), .BLANK_CODE(4'hF), .SKIP_UNCHANGED(1)
    ) dut (
        .clk_in(clk_in), .reset_in(reset_in), .meas_digits(meas_digits), .meas_valid(meas_valid),
        .force_refresh(force_refresh), .digits(digits), .write_stb(write_stb),
        .streamer_ready(streamer_ready), .busy(busy), .pending(pending),
        .drop_cnt(drop_cnt), .timeout_err(timeout_err)
    );

    display_update_scheduler #(
        .DIGITS_NUM(DN), .MIN_INTERVAL(20), .TIMEOUT_CYCLES(50),
        .BLANK_LEADING(0), .BLANK_CODE(4'hF), .SKIP_UNCHANGED(1)
    ) dut_nb (
        .clk_in(clk_in), .reset_in(reset_in), .meas_digits(meas_digits), .meas_valid(meas_valid),
        .force_refresh(force_refresh), .digits(nb_digits), .write_stb(nb_write_stb),
        .streamer_ready(streamer_ready), .busy(nb_busy), .pending(nb_pending),
        .drop_cnt(nb_drop_cnt), .timeout_err(nb_timeout_err)
    );

    always #5 clk_in = ~clk_in;

    // Strobe monitor and data_streamer model: ready drops one cycle after stb for 30 cycles.
    initial begin
        int low_cnt;
        low_cnt = 0;
        streamer_ready = 1'b1;
        forever begin
            @(negedge clk_in);
            if (write_stb) begin
                stb_cnt++;
                stb_dig    = digits;
                stb_dig_nb = nb_digits;
            end
            if (reset_in) begin
                streamer_ready = 1'b1;
                low_cnt = 0;
            end else if (write_stb) begin
                streamer_ready = 1'b0;
                low_cnt = 30;
            end else if (low_cnt > 0 && !stuck) begin
                low_cnt--;
                if (low_cnt == 0) streamer_ready = 1'b1;
            end
        end
    end

    // Displayed form: find the leftmost nonzero nibble (index 0 is leftmost), blank everything before it.
    function automatic logic [DW-1:0] ref_blank(input logic [DW-1:0] v, input bit en);
        logic [DW-1:0] r;
        int first;
        r = v;
        first = DN - 1;
        for (int i = DN - 1; i >= 0; i--) if (v[4*i +: 4] != 4'h0) first = i;
        if (en) for (int i = 0; i < first; i++) r[4*i +: 4] = 4'hF;
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_val();
        logic [DW-1:0] v;
        int z;
        z = $urandom_range(0, DN);
        for (int i = 0; i < DN; i++) v[4*i +: 4] = (i < z) ? 4'h0 : 4'($urandom_range(0, 9));
        return v;
    endfunction

    task automatic pulse_meas(input logic [DW-1:0] v);
        @(negedge clk_in);
        meas_digits = v;
        meas_valid  = 1'b1;
        @(negedge clk_in);
        meas_valid  = 1'b0;
    endtask

    task automatic pulse_force();
        @(negedge clk_in);
        force_refresh = 1'b1;
        @(negedge clk_in);
        force_refresh = 1'b0;
    endtask

    task automatic wait_stb(input int budget, output bit got);
        int s0;
        s0 = stb_cnt;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk_in); #1;
            if (stb_cnt != s0) got = 1'b1;
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk_in); #1;
            if (!busy && streamer_ready) ok = 1'b1;
        end
    endtask

    // Expect a strobe carrying the displayed form of v; records v as last shown.
    task automatic expect_stb(input string name, input logic [DW-1:0] v, input int budget);
        bit got;
        wait_stb(budget, got);
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL %s: no write_stb within %0d cycles, expected digits %h", name, budget, ref_blank(v, 1'b1));
        end else if (stb_dig !== ref_blank(v, 1'b1)) begin
            n_bad++;
            $display("FAIL %s: digits %h expected %h", name, stb_dig, ref_blank(v, 1'b1));
        end
        exp_last = v;
    endtask

    task automatic expect_no_stb(input string name, input int cycles);
        int s0;
        s0 = stb_cnt;
        repeat (cycles) @(negedge clk_in);
        #1;
        n_cmp++;
        if (stb_cnt !== s0 || pending !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: strobes %0d pending %b expected strobes 0 pending 0", name, stb_cnt - s0, pending);
        end
    endtask

    task automatic test_reset();
        reset_in = 1'b1; meas_valid = 1'b0; force_refresh = 1'b0; meas_digits = '0;
        repeat (3) @(negedge clk_in);
        n_cmp++;
        if ({digits, write_stb, busy, pending, drop_cnt, timeout_err} !== '0) begin
            n_bad++;
            $display("FAIL reset: digits %h stb %b busy %b pend %b drop %0d tmo %b expected all 0",
                     digits, write_stb, busy, pending, drop_cnt, timeout_err);
        end
        reset_in = 1'b0;
    endtask

    task automatic test_blanking();
        bit ok;
        // Screen reads "001234": nibble 0 (leftmost) holds the first 0.
        pulse_meas(24'h432100);
        expect_stb("blank_001234", 24'h432100, 10);
        n_cmp++;
        if (stb_dig !== 24'h4321FF) begin
            n_bad++;
            $display("FAIL blank_const: digits %h expected 4321ff", stb_dig);
        end
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin @(negedge clk_in); #1; ok = streamer_ready; end
        ok = 1'b0;
        for (int i = 0; i < 4 && !ok; i++) begin @(negedge clk_in); #1; ok = !busy; end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL busy_release: busy %b expected 0 after ready rise", busy); end
        wait_idle(60, ok);
        pulse_meas(24'h000000);
        expect_stb("blank_zero", 24'h000000, 10);
        n_cmp++;
        if (stb_dig !== 24'h0FFFFF || stb_dig_nb !== 24'h000000) begin
            n_bad++;
            $display("FAIL zero_forms: blanked %h raw %h expected 0fffff 000000", stb_dig, stb_dig_nb);
        end
    endtask

    task automatic test_coalesce();
        bit ok;
        wait_idle(60, ok);
        pulse_meas(24'h987650);
        expect_stb("coalesce_first", 24'h987650, 10);
        pulse_meas(24'h111100); @(negedge clk_in);
        pulse_meas(24'h222000); @(negedge clk_in);
        pulse_meas(24'h345000);
        exp_drop += 2;
        expect_stb("coalesce_last", 24'h345000, 80);
        n_cmp++;
        if (stb_dig !== 24'h345FFF || drop_cnt !== 8'(exp_drop)) begin
            n_bad++;
            $display("FAIL coalesce: digits %h drop %0d expected 345fff drop %0d", stb_dig, drop_cnt, exp_drop);
        end
        wait_idle(60, ok);
        expect_no_stb("coalesce_single", 30);
    endtask

    task automatic test_skip_force();
        bit ok;
        wait_idle(60, ok);
        pulse_meas(24'h506070);
        expect_stb("skip_first", 24'h506070, 10);
        wait_idle(60, ok);
        pulse_meas(24'h506070);
        expect_no_stb("skip_same", 15);
        pulse_force();
        expect_stb("force_same", 24'h506070, 20);
    endtask

    task automatic test_random();
        bit ok;
        logic [DW-1:0] v;
        int k;
        for (int r = 0; r < 8; r++) begin
            wait_idle(80, ok);
            v = ($urandom_range(0, 3) == 0) ? exp_last : rand_val();
            pulse_meas(v);
            if (v == exp_last) begin
                expect_no_stb("rnd_skip", 15);
                pulse_force();
            end
            expect_stb("rnd_issue", v, 20);
            k = $urandom_range(1, 3);
            for (int j = 0; j < k; j++) begin
                v = ($urandom_range(0, 3) == 0) ? exp_last : rand_val();
                pulse_meas(v);
                repeat ($urandom_range(0, 2)) @(negedge clk_in);
            end
            exp_drop += k - 1;
            if (v != exp_last) expect_stb("rnd_latest", v, 80);
            else expect_no_stb("rnd_unchanged", 60);
            n_cmp++;
            if (drop_cnt !== 8'(exp_drop)) begin
                n_bad++;
                $display("FAIL rnd_drop: drop_cnt %0d expected %0d", drop_cnt, exp_drop);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        logic [DW-1:0] v;
        wait_idle(80, ok);
        stuck = 1'b1;
        v = 24'h010203;
        if (v == exp_last) v = 24'h030201;
        pulse_meas(v);
        expect_stb("tmo_issue", v, 10);
        n = 0;
        ok = 1'b0;
        while (n < 100 && !ok) begin @(negedge clk_in); #1; n++; ok = timeout_err; end
        // One cycle in the busy-wait, then fifty waiting for ready to return.
        n_cmp++;
        if (!ok || n != 51 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout: tmo %b after %0d cycles busy %b expected tmo 1 after 51 busy 0", timeout_err, n, busy);
        end
        stuck = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin @(negedge clk_in); #1; ok = streamer_ready; end
        pulse_meas(24'h999999);
        expect_stb("tmo_recover", 24'h999999, 10);
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_idle(80, ok);
        pulse_meas(24'h123456);
        wait_stb(10, ok);
        reset_in = 1'b1;
        @(negedge clk_in); #1;
        n_cmp++;
        if (!ok || {digits, write_stb, busy, pending, drop_cnt, timeout_err} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: stb_seen %b digits %h stb %b busy %b pend %b drop %0d tmo %b expected all 0",
                     ok, digits, write_stb, busy, pending, drop_cnt, timeout_err);
        end
        reset_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_blanking();
        test_coalesce();
        test_skip_force();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
